sobel_window_ctrl: RTL and testbench

SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

---
 rtl/sobel_window_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// 3x3 raster window generator for a Sobel kernel, two line buffers plus shift window.
// Define SOBEL_BORDER_ZERO_EN for one zero-padded window per pixel instead of interior only.
module sobel_window_ctrl #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int BITS_FOR_INDEX = 10,
    parameter int sizeOfWidth    = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [sizeOfWidth-1:0]       in_data,
    output logic                         in_ready,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [9*sizeOfWidth-1:0]     win_data,
    output logic [BITS_FOR_INDEX-1:0]    win_row,
    output logic [BITS_FOR_INDEX-1:0]    win_col,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int ADDR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BITS_FOR_INDEX-1:0] LAST_COL = BITS_FOR_INDEX'(WIDTH - 1);
    localparam logic [BITS_FOR_INDEX-1:0] LAST_ROW = BITS_FOR_INDEX'(HEIGHT - 1);
    localparam logic [BITS_FOR_INDEX-1:0] ONE      = BITS_FOR_INDEX'(1);
    localparam logic [BITS_FOR_INDEX-1:0] TWO      = BITS_FOR_INDEX'(2);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [sizeOfWidth-1:0] lineBuf0 [WIDTH];
    logic [sizeOfWidth-1:0] lineBuf1 [WIDTH];
    logic [sizeOfWidth-1:0] win [9];

    logic [BITS_FOR_INDEX-1:0] row;
    logic [BITS_FOR_INDEX-1:0] col;
    logic                      allIn;
`ifdef SOBEL_BORDER_ZERO_EN
    logic                      padCol;
`endif

    logic                      canAdv;
    logic                      step;
    logic                      emit;
    logic                      lbWrite;
    logic                      lastStep;
    logic                      clearFrame;
    logic [ADDR_W-1:0]         lbAddr;
    logic [sizeOfWidth-1:0]    lbRd0;
    logic [sizeOfWidth-1:0]    lbRd1;
    logic [sizeOfWidth-1:0]    topPix;
    logic [sizeOfWidth-1:0]    midPix;
    logic [sizeOfWidth-1:0]    botPix;
    logic [BITS_FOR_INDEX-1:0] centreRow;
    logic [BITS_FOR_INDEX-1:0] centreCol;

    assign canAdv     = !win_valid || win_ready;
    assign clearFrame = (state == IDLE) && start;
    assign lbAddr     = col[ADDR_W-1:0];
    assign lbRd0      = lineBuf0[lbAddr];
    assign lbRd1      = lineBuf1[lbAddr];
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // lineBuf0 holds the previous row, lineBuf1 the row before it
    always_comb begin
        in_ready  = 1'b0;
        step      = 1'b0;
        lbWrite   = 1'b0;
        emit      = 1'b0;
        lastStep  = 1'b0;
        topPix    = lbRd1;
        midPix    = lbRd0;
        botPix    = in_data;
        centreRow = row - ONE;
        centreCol = col - ONE;
`ifdef SOBEL_BORDER_ZERO_EN
        // Pad steps shift a zero column in after every row; FLUSH feeds a zero row
        in_ready = (state == STREAM) && !padCol && canAdv;
        step     = (in_valid && in_ready)
                 || (((state == STREAM) && padCol) || (state == FLUSH))
                    && !allIn && canAdv;
        lbWrite  = step && !padCol;
        lastStep = step && padCol && (state == FLUSH);
        if (padCol || ((state == STREAM) && (row < TWO))) begin
            topPix = '0;
        end
        if (padCol || ((state == STREAM) && (row == '0))) begin
            midPix = '0;
        end
        if (padCol || (state == FLUSH)) begin
            botPix = '0;
        end
        emit = (padCol || (col != '0)) && ((state == FLUSH) || (row != '0));
        if (state == FLUSH) begin
            centreRow = LAST_ROW;
        end
        if (padCol) begin
            centreCol = LAST_COL;
        end
`else
        in_ready = (state == STREAM) && !allIn && canAdv;
        step     = in_valid && in_ready;
        lbWrite  = step;
        lastStep = step && (row == LAST_ROW) && (col == LAST_COL);
        emit     = (row >= TWO) && (col >= TWO);
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            row   <= '0;
            col   <= '0;
            allIn <= 1'b0;
`ifdef SOBEL_BORDER_ZERO_EN
            padCol <= 1'b0;
`endif
        end else if (clearFrame) begin
            row   <= '0;
            col   <= '0;
            allIn <= 1'b0;
`ifdef SOBEL_BORDER_ZERO_EN
            padCol <= 1'b0;
`endif
        end else if (step) begin
            if (lastStep) begin
                allIn <= 1'b1;
            end
`ifdef SOBEL_BORDER_ZERO_EN
            if (padCol) begin
                padCol <= 1'b0;
                col    <= '0;
                if ((state == STREAM) && (row != LAST_ROW)) begin
                    row <= row + ONE;
                end
            end else if (col == LAST_COL) begin
                padCol <= 1'b1;
            end else begin
                col <= col + ONE;
            end
`else
            if (col == LAST_COL) begin
                col <= '0;
                if (row != LAST_ROW) begin
                    row <= row + ONE;
                end
            end else begin
                col <= col + ONE;
            end
`endif
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else if (clearFrame) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
        end else if (step) begin
            win[0]    <= win[1];
            win[1]    <= win[2];
            win[2]    <= topPix;
            win[3]    <= win[4];
            win[4]    <= win[5];
            win[5]    <= midPix;
            win[6]    <= win[7];
            win[7]    <= win[8];
            win[8]    <= botPix;
            win_valid <= emit;
            if (emit) begin
                win_row <= centreRow;
                win_col <= centreCol;
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (lbWrite) begin
            lineBuf1[lbAddr] <= lbRd0;
            lineBuf0[lbAddr] <= botPix;
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < 9; i++) begin
            win_data[i*sizeOfWidth +: sizeOfWidth] = win[i];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    stateNext = STREAM;
                end
            end
            STREAM: begin
`ifdef SOBEL_BORDER_ZERO_EN
                if (step && padCol && (row == LAST_ROW)) begin
                    stateNext = FLUSH;
                end
`else
                if (allIn && win_valid && win_ready) begin
                    stateNext = DONE;
                end
`endif
            end
            FLUSH: begin
                if (allIn && win_valid && win_ready) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl on a 4x4 frame with pixel value 4*r+c.
// Expected windows come from a direct 3x3 neighbourhood model of the image.
module tb_sobel_window_ctrl;

    localparam int W = 4;
    localparam int H = 4;
    localparam int B = 4;
    localparam int S = 8;
`ifdef SOBEL_BORDER_ZERO_EN
    localparam bit BORDER = 1'b1;
    localparam int N_WIN  = 16;
`else
    localparam bit BORDER = 1'b0;
    localparam int N_WIN  = 4;
`endif

    // taps packed p22..p00 from MSB to LSB
    localparam logic [9*S-1:0] PIN11 =
        {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    localparam logic [9*S-1:0] PIN00 =
        {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic [9*S-1:0] PIN33 =
        {8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd14, 8'd0, 8'd11, 8'd10};

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic           start;
    logic           in_valid;
    logic [S-1:0]   in_data;
    logic           in_ready;
    logic           win_valid;
    logic           win_ready;
    logic [9*S-1:0] win_data;
    logic [B-1:0]   win_row;
    logic [B-1:0]   win_col;
    logic           busy;
    logic           frame_done;

    sobel_window_ctrl #(
        .WIDTH(W),
        .HEIGHT(H),
        .BITS_FOR_INDEX(B),
        .sizeOfWidth(S)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_data(win_data),
        .win_row(win_row),
        .win_col(win_col),
        .busy(busy),
        .frame_done(frame_done)
    );

    initial forever #5 HCLK = ~HCLK;

    typedef struct {
        int             r;
        int             c;
        logic [9*S-1:0] d;
    } win_t;

    win_t           expQ[$];
    int             nChecks = 0;
    int             nFails = 0;
    int             readyMode = 0;
    bit             monEn = 1'b0;
    int             doneState = 0;
    bit             frameEnded = 1'b0;
    int             winCount = 0;
    bit             stalled = 1'b0;
    logic [9*S-1:0] snapD;
    logic [B-1:0]   snapR;
    logic [B-1:0]   snapC;

    task automatic chkEq(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pix(int r, int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
        return 4 * r + c;
    endfunction

    function automatic logic [9*S-1:0] taps(int r, int c);
        logic [9*S-1:0] d = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                d[((dr + 1) * 3 + dc + 1) * S +: S] = S'(pix(r + dr, c + dc));
            end
        end
        return d;
    endfunction

    task automatic buildModel();
        expQ.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (BORDER || (r >= 1 && r <= H - 2 && c >= 1 && c <= W - 2)) begin
                    expQ.push_back('{r, c, taps(r, c)});
                end
            end
        end
    endtask

    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge HCLK);
            #1;
            case (readyMode)
                1: win_ready = !win_ready;
                2: win_ready = 1'($urandom_range(0, 1));
                default: win_ready = 1'b1;
            endcase
        end
    end

    always @(negedge HCLK) begin
        if (monEn) begin
            if (doneState == 1) begin
                chkEq("frame_done_pulse", 128'(frame_done), 128'(1));
                chkEq("busy_in_done", 128'(busy), 128'(1));
                doneState = 2;
            end else if (doneState == 2) begin
                chkEq("frame_done_clear", 128'(frame_done), 128'(0));
                chkEq("busy_idle", 128'(busy), 128'(0));
                doneState = 0;
                frameEnded = 1'b1;
            end else if (frame_done) begin
                chkEq("spurious_frame_done", 128'(frame_done), 128'(0));
            end
            if (stalled) begin
                chkEq("stall_valid", 128'(win_valid), 128'(1));
                chkEq("stall_data", 128'(win_data), 128'(snapD));
                chkEq("stall_row", 128'(win_row), 128'(snapR));
                chkEq("stall_col", 128'(win_col), 128'(snapC));
            end
            if (win_valid && !win_ready) begin
                chkEq("in_ready_stall", 128'(in_ready), 128'(0));
            end
            if (win_valid) begin
                chkEq("busy_with_window", 128'(busy), 128'(1));
            end
            stalled = win_valid && !win_ready;
            snapD = win_data;
            snapR = win_row;
            snapC = win_col;
            if (win_valid && win_ready) begin
                winCount++;
                if (expQ.size() == 0) begin
                    chkEq("extra_window", 128'(winCount), 128'(N_WIN));
                end else begin
                    win_t e;
                    e = expQ.pop_front();
                    chkEq("win_row", 128'(win_row), 128'(e.r));
                    chkEq("win_col", 128'(win_col), 128'(e.c));
                    chkEq("win_data", 128'(win_data), 128'(e.d));
`ifdef SOBEL_BORDER_ZERO_EN
                    if (win_row == 0 && win_col == 0) begin
                        chkEq("pin_centre00", 128'(win_data), 128'(PIN00));
                    end
                    if (win_row == 3 && win_col == 3) begin
                        chkEq("pin_centre33", 128'(win_data), 128'(PIN33));
                    end
`else
                    if (win_row == 1 && win_col == 1) begin
                        chkEq("pin_centre11", 128'(win_data), 128'(PIN11));
                    end
`endif
                    if (expQ.size() == 0) begin
                        doneState = 1;
                    end
                end
            end
        end
    end

    task automatic startFrame();
        buildModel();
        winCount   = 0;
        frameEnded = 1'b0;
        doneState  = 0;
        stalled    = 1'b0;
        monEn      = 1'b1;
        start      = 1'b1;
        @(posedge HCLK);
        #1;
        start = 1'b0;
    endtask

    task automatic sendPixels(input int n, input int gap, input bit poke);
        int k = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (k < n) begin
                    bit acc = 1'b0;
                    int waited = 0;
                    in_valid = 1'b1;
                    in_data  = S'(pix(r, c));
                    if (poke && k == 5) start = 1'b1;
                    while (!acc && waited < 50) begin
                        @(negedge HCLK);
                        acc = in_ready;
                        @(posedge HCLK);
                        #1;
                        start = 1'b0;
                        waited++;
                    end
                    chkEq("pixel_accepted", 128'(acc), 128'(1));
                    in_valid = 1'b0;
                    repeat (gap) begin
                        @(posedge HCLK);
                        #1;
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic waitFrameEnd();
        int n = 0;
        while (!frameEnded && n < 200) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        chkEq("frame_end_seen", 128'(frameEnded), 128'(1));
        chkEq("window_count", 128'(winCount), 128'(N_WIN));
        chkEq("model_drained", 128'(expQ.size()), 128'(0));
    endtask

    task automatic checkResetOutputs(input string tag);
        chkEq({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        chkEq({tag, "_win_valid"}, 128'(win_valid), 128'(0));
        chkEq({tag, "_busy"}, 128'(busy), 128'(0));
        chkEq({tag, "_frame_done"}, 128'(frame_done), 128'(0));
        chkEq({tag, "_win_data"}, 128'(win_data), 128'(0));
        chkEq({tag, "_win_row"}, 128'(win_row), 128'(0));
        chkEq({tag, "_win_col"}, 128'(win_col), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn  = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        checkResetOutputs("reset");
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        readyMode = 0;
        startFrame();
        sendPixels(W * H, 0, 1'b0);
        waitFrameEnd();

        readyMode = 1;
        @(posedge HCLK);
        #1;
        startFrame();
        sendPixels(W * H, 0, 1'b0);
        waitFrameEnd();

        readyMode = 0;
        @(posedge HCLK);
        #1;
        startFrame();
        sendPixels(7, 0, 1'b0);
        monEn = 1'b0;
        #2;
        HRESETn = 1'b0;
        #1;
        checkResetOutputs("midreset");
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        checkResetOutputs("after_reset");
        startFrame();
        sendPixels(W * H, 0, 1'b0);
        waitFrameEnd();

        startFrame();
        sendPixels(W * H, 3, 1'b1);
        waitFrameEnd();

        readyMode = 2;
        @(posedge HCLK);
        #1;
        startFrame();
        sendPixels(W * H, 1, 1'b0);
        waitFrameEnd();

        readyMode = 0;
        monEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
